nonce_issue: RTL and testbench

- Issues nonces to the hashing core, one per clock, over a programmed inclusive range.
- Each nonce is driven in the core's bit-reversed format.
- After the last issue, the block waits out the core pipeline depth before signalling the job complete, so late hits are still attributed to the job.
- Sits between the job loader (host/UART side) and the hashing core input. It is the issuing counterpart of the nonce correction path on the core output.

---
 rtl/nonce_pkg.sv | 24 ++
 rtl/nonce_issue.sv | 138 +++++++++++++
 tb/tb_nonce_issue.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/nonce_pkg.sv
// Types and helpers shared by the nonce issue path and the nonce correction path on the core output.
// Both ends use bit_rev so they always agree on the core's nonce bit order.
package nonce_pkg;

   localparam int NONCE_W        = 32;
   localparam int PIPE_DEPTH_DEF = 32'hC0;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } state_t;

   // Bit i of the true nonce lands on bit NONCE_W-1-i of the core's format.
   function automatic logic [NONCE_W-1:0] bit_rev(input logic [NONCE_W-1:0] x);
      logic [NONCE_W-1:0] r;
      r = '0;
      for (int i = 0; i < NONCE_W; i++) begin
         r[NONCE_W-1-i] = x[i];
      end
      return r;
   endfunction

endpackage

// File: rtl/nonce_issue.sv
// Issues one nonce per clock over an inclusive, possibly wrapping, range, then waits out
// the core pipeline before pulsing done so late hits still belong to this job.
module nonce_issue
   import nonce_pkg::*;
#(
   parameter int PIPE_DEPTH = PIPE_DEPTH_DEF,
   parameter bit REVERSE    = 1'b1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               job_valid,
   output logic               job_ready,
   input  logic [NONCE_W-1:0] start_nonce,
   input  logic [NONCE_W-1:0] end_nonce,
   input  logic               abort,
   output logic               core_valid,
   output logic [NONCE_W-1:0] core_nonce,
   output logic [NONCE_W-1:0] cur_nonce,
   output logic               busy,
   output logic               done
);

   localparam int DRAIN_W = $clog2(PIPE_DEPTH + 1);
   localparam logic [DRAIN_W-1:0] DRAIN_LOAD = DRAIN_W'(PIPE_DEPTH - 1);

   generate
      if (PIPE_DEPTH < 1) begin : g_bad_depth
         $error("nonce_issue: PIPE_DEPTH must be >= 1");
      end
   endgenerate

   state_t               state_reg, state_next;
   logic [NONCE_W-1:0]   cnt_reg, cnt_next;
   logic [NONCE_W-1:0]   end_reg, end_next;
   logic [DRAIN_W-1:0]   drain_reg, drain_next;
   logic                 valid_reg, valid_next;
   logic [NONCE_W-1:0]   core_nonce_reg, core_nonce_next;
   logic [NONCE_W-1:0]   cur_reg, cur_next;
   logic                 busy_reg, busy_next;
   logic                 done_reg, done_next;
   logic                 ready_reg, ready_next;

   function automatic logic [NONCE_W-1:0] to_core(input logic [NONCE_W-1:0] x);
      return REVERSE ? bit_rev(x) : x;
   endfunction

   always_comb begin
      state_next      = state_reg;
      cnt_next        = cnt_reg;
      end_next        = end_reg;
      drain_next      = drain_reg;
      valid_next      = valid_reg;
      core_nonce_next = core_nonce_reg;
      cur_next        = cur_reg;
      done_next       = 1'b0;

      case (state_reg)
         IDLE: begin
            if (job_valid) begin
               state_next      = RUN;
               end_next        = end_nonce;
               valid_next      = 1'b1;
               cur_next        = start_nonce;
               core_nonce_next = to_core(start_nonce);
               cnt_next        = start_nonce + 32'd1;
            end
         end
         RUN: begin
            if (abort) begin
               state_next = IDLE;
               valid_next = 1'b0;
            end else if (cur_reg == end_reg) begin
               // The nonce now on the bus is the last one; its core_valid cycle ends here.
               state_next = DRAIN;
               valid_next = 1'b0;
               drain_next = DRAIN_LOAD;
               done_next  = (PIPE_DEPTH == 1);
            end else begin
               valid_next      = 1'b1;
               cur_next        = cnt_reg;
               core_nonce_next = to_core(cnt_reg);
               cnt_next        = cnt_reg + 32'd1;
            end
         end
         DRAIN: begin
            if (abort || done_reg) begin
               state_next = IDLE;
            end else if (drain_reg == DRAIN_W'(1)) begin
               done_next  = 1'b1;
               drain_next = '0;
            end else begin
               drain_next = drain_reg - DRAIN_W'(1);
            end
         end
         default: begin
            state_next = IDLE;
            valid_next = 1'b0;
         end
      endcase

      busy_next  = (state_next != IDLE);
      ready_next = (state_next == IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg      <= IDLE;
         cnt_reg        <= '0;
         end_reg        <= '0;
         drain_reg      <= '0;
         valid_reg      <= 1'b0;
         core_nonce_reg <= '0;
         cur_reg        <= '0;
         busy_reg       <= 1'b0;
         done_reg       <= 1'b0;
         ready_reg      <= 1'b1;
      end else begin
         state_reg      <= state_next;
         cnt_reg        <= cnt_next;
         end_reg        <= end_next;
         drain_reg      <= drain_next;
         valid_reg      <= valid_next;
         core_nonce_reg <= core_nonce_next;
         cur_reg        <= cur_next;
         busy_reg       <= busy_next;
         done_reg       <= done_next;
         ready_reg      <= ready_next;
      end
   end

   assign core_valid = valid_reg;
   assign core_nonce = core_nonce_reg;
   assign cur_nonce  = cur_reg;
   assign busy       = busy_reg;
   assign done       = done_reg;
   assign job_ready  = ready_reg;

endmodule

// File: tb/tb_nonce_issue.sv
// Scoreboard bench: stimulus queues expected issues and done pulses; a negedge monitor pops and compares.
// Two instances share inputs, one reversing and one pass-through, so both output formats are checked.
module tb_nonce_issue;

   localparam int D = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        job_valid = 1'b0;
   logic        abort = 1'b0;
   logic [31:0] start_nonce = '0;
   logic [31:0] end_nonce = '0;

   logic        ready_r, valid_r, busy_r, done_r;
   logic [31:0] nonce_r, cur_r;
   logic        ready_f, valid_f, busy_f, done_f;
   logic [31:0] nonce_f, cur_f;

   int cyc = 0;
   int n_chk = 0;
   int n_fail = 0;

   typedef struct {
      int          cyc;
      logic [31:0] cur;
      logic [31:0] rev;
   } issue_t;

   issue_t exp_q[$];
   int     done_q[$];

   nonce_issue #(.PIPE_DEPTH(D), .REVERSE(1'b1)) u_rev (
      .clk(clk), .rst(rst), .job_valid(job_valid), .job_ready(ready_r),
      .start_nonce(start_nonce), .end_nonce(end_nonce), .abort(abort),
      .core_valid(valid_r), .core_nonce(nonce_r), .cur_nonce(cur_r),
      .busy(busy_r), .done(done_r)
   );

   nonce_issue #(.PIPE_DEPTH(D), .REVERSE(1'b0)) u_fwd (
      .clk(clk), .rst(rst), .job_valid(job_valid), .job_ready(ready_f),
      .start_nonce(start_nonce), .end_nonce(end_nonce), .abort(abort),
      .core_valid(valid_f), .core_nonce(nonce_f), .cur_nonce(cur_f),
      .busy(busy_f), .done(done_f)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [31:0] tb_rev(input logic [31:0] x);
      logic [31:0] r;
      r = {<<{x}};
      return r;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s @cyc %0d: got %h want %h", name, cyc, act, exp);
      end else begin
         $display("ok   %s @cyc %0d: %h", name, cyc, act);
      end
   endtask

   // Monitor: every issue and every done pulse must match the head of its queue.
   always @(negedge clk) begin
      issue_t e;
      if (valid_r || valid_f) begin
         chk("valid_agree", {31'b0, valid_f}, {31'b0, valid_r});
         if (exp_q.size() == 0) begin
            chk("unexpected_issue", cur_r, 32'hDEAD_BEEF);
         end else begin
            e = exp_q.pop_front();
            chk("issue_cycle", cyc, e.cyc);
            chk("cur_rev", cur_r, e.cur);
            chk("cur_fwd", cur_f, e.cur);
            chk("core_rev", nonce_r, e.rev);
            chk("core_fwd", nonce_f, e.cur);
         end
      end else if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
         e = exp_q.pop_front();
         chk("missed_issue", cyc, e.cyc - 1);
      end
      if (done_r || done_f) begin
         chk("done_agree", {31'b0, done_f}, {31'b0, done_r});
         if (done_q.size() == 0) chk("unexpected_done", cyc, 0);
         else chk("done_cycle", cyc, done_q.pop_front());
      end else if (done_q.size() > 0 && done_q[0] <= cyc) begin
         chk("missed_done", cyc, done_q.pop_front() - 1);
      end
   end

   task automatic tick();
      @(negedge clk);
      job_valid = 1'b0;
      abort     = 1'b0;
   endtask

   task automatic wait_until(input int c);
      while (cyc < c) tick();
   endtask

   task automatic wait_ready();
      int k = 0;
      while (!(ready_r && ready_f) && k < 60) begin
         tick();
         k++;
      end
      chk("ready_timeout", {31'b0, ready_r && ready_f}, 32'd1);
   endtask

   // Drives a job in the current cycle T; queues n_push sequential issues and, if n_done>0, done at T+n_done+D.
   task automatic start_job(input logic [31:0] s, input logic [31:0] e, input int n_push,
                            input int n_done, output int t);
      issue_t it;
      job_valid   = 1'b1;
      start_nonce = s;
      end_nonce   = e;
      t = cyc;
      for (int i = 0; i < n_push; i++) begin
         it.cyc = t + 1 + i;
         it.cur = s + 32'(i);
         it.rev = tb_rev(it.cur);
         exp_q.push_back(it);
      end
      if (n_done > 0) done_q.push_back(t + n_done + D);
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_ctl_rev"}, {28'b0, valid_r, busy_r, done_r, ready_r}, 32'h1);
      chk({tag, "_ctl_fwd"}, {28'b0, valid_f, busy_f, done_f, ready_f}, 32'h1);
      chk({tag, "_nonce"}, nonce_r | nonce_f, 32'h0);
      chk({tag, "_cur"}, cur_r | cur_f, 32'h0);
   endtask

   initial begin
      int t;
      logic [31:0] basic_rev [4];
      issue_t it;
      basic_rev[0] = 32'h0000_0000;
      basic_rev[1] = 32'h8000_0000;
      basic_rev[2] = 32'h4000_0000;
      basic_rev[3] = 32'hC000_0000;

      tick();
      tick();
      rst = 1'b0;
      chk_reset_outputs("reset");

      // Basic range 0..3 with hand-computed reversed nonces.
      start_job(32'd0, 32'd3, 0, 4, t);
      for (int i = 0; i < 4; i++) begin
         it.cyc = t + 1 + i;
         it.cur = 32'(i);
         it.rev = basic_rev[i];
         exp_q.push_back(it);
      end
      tick();
      wait_until(t + 8);
      chk("basic_ready_at_done", {30'b0, ready_r, busy_r}, 32'h1);
      tick();
      chk("basic_ready_after", {30'b0, ready_r, busy_r}, 32'h2);
      chk("basic_ready_fwd", {30'b0, ready_f, busy_f}, 32'h2);

      // Wrapping range across 2^32.
      start_job(32'hFFFF_FFFE, 32'h0000_0001, 4, 4, t);
      tick();
      wait_ready();

      // Single nonce.
      start_job(32'h1234_5678, 32'h1234_5678, 1, 1, t);
      tick();
      wait_ready();

      // Abort on the second RUN cycle.
      start_job(32'd100, 32'd109, 2, 0, t);
      tick();
      wait_until(t + 2);
      abort = 1'b1;
      tick();
      chk("abort_state", {29'b0, valid_r, busy_r, ready_r}, 32'h1);
      abort = 1'b1;
      start_job(32'd5, 32'd6, 2, 2, t);
      tick();
      wait_ready();

      // job_valid during DRAIN is ignored; done stays on schedule.
      start_job(32'd20, 32'd21, 2, 2, t);
      tick();
      wait_until(t + 4);
      chk("drain_busy", {30'b0, busy_r, ready_r}, 32'h2);
      job_valid   = 1'b1;
      start_nonce = 32'd999;
      end_nonce   = 32'd999;
      tick();
      wait_ready();

      // Reset mid-RUN drops the job silently.
      start_job(32'd40, 32'd49, 3, 0, t);
      tick();
      wait_until(t + 3);
      rst = 1'b1;
      tick();
      chk_reset_outputs("midrun_rst");
      rst = 1'b0;

      repeat (20) tick();
      chk("issues_left", exp_q.size(), 32'd0);
      chk("dones_left", done_q.size(), 32'd0);

      $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
      $finish;
   end

endmodule
